// File: rtl/lvds_tx_pkg.sv
// Shared types and sizing helpers for the LVDS serial transmitter.
package lvds_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

  // Bit-counter width; a 2-bit word still needs one counter bit.
  function automatic int cnt_w(input int dw);
    return (dw <= 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/cmos_to_lvds.sv
// Single-ended to differential output buffer, one pair per bus bit (p = in, n = ~in).
module cmos_to_lvds #(
  parameter int    BUS_WIDTH  = 1,
  parameter string IOSTANDARD = "DEFAULT"
) (
  input  logic [BUS_WIDTH-1:0] din_i,
  output logic [BUS_WIDTH-1:0] dout_p_o,
  output logic [BUS_WIDTH-1:0] dout_n_o
);

  // The behavioural pair model only stands in for the default pad standard.
  if (IOSTANDARD != "DEFAULT") begin : g_bad_std
    $error("cmos_to_lvds: unsupported IOSTANDARD");
  end

  for (genvar b = 0; b < BUS_WIDTH; b++) begin : g_pair
    assign dout_p_o[b] = din_i[b];
    assign dout_n_o[b] = ~din_i[b];
  end

endmodule

// File: rtl/lvds_serial_tx.sv
// LVDS transmit serializer: valid/ready word intake, one bit per clock on the data
// pair, frame pair high on the first bit of each word; back-to-back words run gapless.
module lvds_serial_tx
  import lvds_tx_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  data_s,
  output logic                  frame_s,
  output logic                  data_p,
  output logic                  data_n,
  output logic                  frame_p,
  output logic                  frame_n
);

  if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_width
    $error("lvds_serial_tx: DATA_WIDTH must be 2..32");
  end

  localparam int          CW   = cnt_w(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  last_bit, accept;

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
  assign tx_ready = (state_q == IDLE) || last_bit;
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sh_d    = tx_data;
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      // The bit on the lane is always at the outgoing end of the shift register.
      sh_d = MSB_FIRST ? {sh_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, sh_q[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign data_s  = busy ? (MSB_FIRST ? sh_q[DATA_WIDTH-1] : sh_q[0]) : IDLE_BIT;
  assign frame_s = busy && (cnt_q == '0);

  logic [1:0] pad_p, pad_n;

  cmos_to_lvds #(
    .BUS_WIDTH (2),
    .IOSTANDARD("DEFAULT")
  ) u_obuf (
    .din_i   ({frame_s, data_s}),
    .dout_p_o(pad_p),
    .dout_n_o(pad_n)
  );

  assign data_p  = pad_p[0];
  assign data_n  = pad_n[0];
  assign frame_p = pad_p[1];
  assign frame_n = pad_n[1];

endmodule

// File: tb/tb_lvds_serial_tx.sv
// Scoreboard bench for lvds_serial_tx: MSB-first instance for most tests, LSB-first instance for bit order.
module tb_lvds_serial_tx;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       valid_l = 1'b0;

  logic tx_ready, busy, data_s, frame_s, data_p, data_n, frame_p, frame_n;
  logic rdy_l, busy_l, data_l, frame_l, dp_l, dn_l, fp_l, fn_l;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic d;
    logic f;
    int   cnt;
  } exp_t;
  exp_t sbq[$];

  always #5 clock = ~clock;

  lvds_serial_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clock(clock), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .data_s(data_s), .frame_s(frame_s),
    .data_p(data_p), .data_n(data_n), .frame_p(frame_p), .frame_n(frame_n)
  );

  lvds_serial_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clock(clock), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(valid_l),
    .tx_ready(rdy_l), .busy(busy_l), .data_s(data_l), .frame_s(frame_l),
    .data_p(dp_l), .data_n(dn_l), .frame_p(fp_l), .frame_n(fn_l)
  );

  // Reference serialization: bit i of the stream, frame on bit 0 only.
  task automatic push_word(input logic [7:0] w, input bit msb);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.d   = msb ? w[7-i] : w[i];
      e.f   = (i == 0);
      e.cnt = i;
      sbq.push_back(e);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({data_s, frame_s, busy, tx_ready, data_p, data_n, frame_p, frame_n} !== 8'b0001_0101) begin
      failures++;
      $display("FAIL reset_hold: got %b want 00010101",
               {data_s, frame_s, busy, tx_ready, data_p, data_n, frame_p, frame_n});
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      checks++;
      if ({data_s, frame_s, busy, tx_ready, data_p, data_n} !== 6'b000101) begin
        failures++;
        $display("FAIL idle_cycle%0d: got %b want 000101", c,
                 {data_s, frame_s, busy, tx_ready, data_p, data_n});
      end
    end
  endtask

  task automatic test_single(input logic [7:0] w, input string nm);
    exp_t e;
    @(negedge clock);
    tx_data  = w;
    tx_valid = 1'b1;
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_idle: got %b want 1", nm, tx_ready);
    end
    @(posedge clock);
    push_word(w, 1'b1);
    while (sbq.size() > 0) begin
      @(negedge clock);
      tx_valid = 1'b0;
      e = sbq.pop_front();
      checks++;
      if ({data_s, frame_s, busy, tx_ready, data_p, data_n, frame_p, frame_n} !==
          {e.d, e.f, 1'b1, (e.cnt == 7), e.d, ~e.d, e.f, ~e.f}) begin
        failures++;
        $display("FAIL %s_bit%0d: got d=%b f=%b busy=%b rdy=%b want d=%b f=%b busy=1 rdy=%b",
                 nm, e.cnt, data_s, frame_s, busy, tx_ready, e.d, e.f, (e.cnt == 7));
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++;
      if ({data_s, frame_s, busy, tx_ready} !== 4'b0001) begin
        failures++;
        $display("FAIL %s_after_idle: got %b want 0001", nm, {data_s, frame_s, busy, tx_ready});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [3];
    int idx = 1;
    int nbits = 0;
    exp_t e;
    words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'h81;
    @(negedge clock);
    tx_data  = words[0];
    tx_valid = 1'b1;
    @(posedge clock);
    push_word(words[0], 1'b1);
    while (sbq.size() > 0 && nbits < 40) begin
      @(negedge clock);
      e = sbq.pop_front();
      checks++;
      if ({data_s, frame_s, busy, tx_ready} !== {e.d, e.f, 1'b1, (e.cnt == 7)}) begin
        failures++;
        $display("FAIL b2b_off%0d: got d=%b f=%b busy=%b rdy=%b want d=%b f=%b busy=1 rdy=%b",
                 nbits, data_s, frame_s, busy, tx_ready, e.d, e.f, (e.cnt == 7));
      end
      nbits++;
      if (e.cnt == 7) begin
        if (idx < 3) begin
          tx_data = words[idx];
          push_word(words[idx], 1'b1);
          idx++;
        end else begin
          tx_valid = 1'b0;
        end
      end
    end
    checks++;
    if (nbits !== 24) begin
      failures++;
      $display("FAIL b2b_len: got %0d bits want 24", nbits);
    end
    @(negedge clock);
    checks++;
    if ({data_s, frame_s, busy} !== 3'b000) begin
      failures++;
      $display("FAIL b2b_end_idle: got %b want 000", {data_s, frame_s, busy});
    end
  endtask

  task automatic test_lsb_first;
    exp_t e;
    @(negedge clock);
    tx_data = 8'h01;
    valid_l = 1'b1;
    @(posedge clock);
    push_word(8'h01, 1'b0);
    while (sbq.size() > 0) begin
      @(negedge clock);
      valid_l = 1'b0;
      e = sbq.pop_front();
      checks++;
      if ({data_l, frame_l, busy_l, dp_l, dn_l} !== {e.d, e.f, 1'b1, e.d, ~e.d}) begin
        failures++;
        $display("FAIL lsb_bit%0d: got d=%b f=%b busy=%b want d=%b f=%b busy=1",
                 e.cnt, data_l, frame_l, busy_l, e.d, e.f);
      end
    end
    @(negedge clock);
    checks++;
    if ({data_l, busy_l, busy} !== 3'b000) begin
      failures++;
      $display("FAIL lsb_end_idle: got %b want 000", {data_l, busy_l, busy});
    end
  endtask

  task automatic test_reset_mid_word;
    exp_t e;
    @(negedge clock);
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    @(posedge clock);
    push_word(8'hF0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      tx_valid = 1'b0;
      e = sbq.pop_front();
      checks++;
      if ({data_s, frame_s} !== {e.d, e.f}) begin
        failures++;
        $display("FAIL rst_pre_bit%0d: got d=%b f=%b want d=%b f=%b", i, data_s, frame_s, e.d, e.f);
      end
    end
    reset_n = 1'b0;
    #1;
    sbq.delete();
    checks++;
    if ({data_s, frame_s, busy, tx_ready, data_p, data_n} !== 6'b000101) begin
      failures++;
      $display("FAIL rst_async_idle: got %b want 000101",
               {data_s, frame_s, busy, tx_ready, data_p, data_n});
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, tx_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rst_release: got busy/rdy=%b want 01", {busy, tx_ready});
    end
    test_single(8'h3C, "post_rst");
  endtask

  task automatic test_input_hold;
    exp_t e;
    @(negedge clock);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(posedge clock);
    push_word(8'h5A, 1'b1);
    while (sbq.size() > 0) begin
      @(negedge clock);
      e = sbq.pop_front();
      checks++;
      if ({data_s, frame_s, busy, tx_ready} !== {e.d, e.f, 1'b1, (e.cnt == 7)}) begin
        failures++;
        $display("FAIL hold_bit%0d: got d=%b f=%b busy=%b rdy=%b want d=%b f=%b busy=1 rdy=%b",
                 e.cnt, data_s, frame_s, busy, tx_ready, e.d, e.f, (e.cnt == 7));
      end
      tx_data  = 8'($urandom);
      tx_valid = (e.cnt == 7) ? 1'b0 : ~tx_valid;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if ({data_s, frame_s, busy} !== 3'b000) begin
        failures++;
        $display("FAIL hold_no_extra%0d: got %b want 000", c, {data_s, frame_s, busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5, "single_a5");
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    test_input_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lvds_serial_tx.md
Name: lvds_serial_tx

Overview:
Transmit end of the board's LVDS links. Accepts parallel words from fabric logic over a valid/ready handshake and shifts them out one bit per clock on a differential data pair, with a differential frame pair marking the first bit of each word. Single-ended copies of both lanes are driven through a CMOS-to-LVDS output buffer stage to the top-level pads. Sits between user transmit logic and the output pins.

Parameters:
DATA_WIDTH, 8, bits per word; legal range 2..32, checked at elaboration.
MSB_FIRST, 1, 1 = bit DATA_WIDTH-1 shifted first; 0 = bit 0 first.
IDLE_BIT, 0, level held on the data lane when no word is in flight.

Ports:
clock  input  1  transmit bit clock; all flops on rising edge.
reset_n  input  1  asynchronous, active-low reset.
tx_data  input  DATA_WIDTH  word to send; sampled only on the accept edge.
tx_valid  input  1  tx_data is valid.
tx_ready  output  1  block can accept a word this cycle.
busy  output  1  a word is being shifted.
data_s  output  1  single-ended data lane before the output buffer (debug/verification).
frame_s  output  1  single-ended frame lane before the output buffer.
data_p / data_n  output  1 each  differential data pair, to top-level pads.
frame_p / frame_n  output  1 each  differential frame pair, to top-level pads.

Behaviour:
- One clock domain (clock). Reset is asynchronous and active-low (reset_n). No other clocks.
- State machine: IDLE, SHIFT.
- Accept = tx_valid && tx_ready at a rising edge.
- tx_ready = (state==IDLE) || (state==SHIFT && bit_cnt==DATA_WIDTH-1). This is combinational from registered state and has no dependence on tx_valid.
- On accept: load shift register with tx_data, set bit_cnt=0, state=SHIFT. Registered outputs take the first bit immediately after that edge. Latency is 1 cycle from the accept edge to the first bit on data_s.
- SHIFT: data_s carries the current bit for exactly one cycle. frame_s=1 only while bit_cnt==0, otherwise 0. bit_cnt increments each edge.
- Final bit (bit_cnt==DATA_WIDTH-1):
  - If accept occurs: reload and restart at bit_cnt=0. There is no gap, and frame_s pulses on the next cycle. Back-to-back streaming gives 100% lane utilisation.
  - If no accept: state goes to IDLE.
- IDLE: data_s=IDLE_BIT, frame_s=0, busy=0.
- busy = (state==SHIFT).
- Bit order is set by MSB_FIRST. Shifting uses the shift register only; no arithmetic beyond bit_cnt, which is a ceil(log2(DATA_WIDTH))-bit counter that never wraps past DATA_WIDTH-1.
- Changes to tx_data or tx_valid after the accept edge have no effect on the word in flight. tx_valid held low leaves the lanes idle indefinitely.
- Reset values while reset_n=0:
  - state=IDLE, bit_cnt=0, shift register=0.
  - data_s=IDLE_BIT, frame_s=0, busy=0.
  - tx_ready=1, but no accept can occur while reset is held.
- Reset asserted mid-word: outputs go to idle values asynchronously and the partial word is dropped. After deassertion the block is in IDLE with tx_ready=1.
- Differential outputs follow data_s/frame_s through the buffer with no added register stage. Pair polarity: p = signal, n = complement.

Decomposition:
- Package lvds_tx_pkg: state enum (IDLE, SHIFT) and the bit-counter width function (clog2-based).
- Sub-module cmos_to_lvds: BUS_WIDTH parameter, one differential output buffer per bit, IOSTANDARD "DEFAULT". It is instantiated once here with BUS_WIDTH=2 for {frame_s, data_s}. It is the output-side counterpart of the team's LVDS input buffer wrapper and is reusable elsewhere.

Test Plan:
1. Reset then idle (DATA_WIDTH=8, IDLE_BIT=0) -> data_s=0, frame_s=0, busy=0, tx_ready=1 for 20 cycles; data_p=0, data_n=1.
2. Single word 0xA5, MSB_FIRST=1 -> starting the cycle after the accept edge, data_s=1,0,1,0,0,1,0,1. frame_s is high only on the first bit. busy is high 8 cycles. Then idle.
3. Back-to-back 0xFF, 0x00, 0x81 with tx_valid held high -> 24 contiguous bits with no gap. frame_s pulses at bit offsets 0, 8, 16. tx_ready is high only in cycles where bit_cnt==7.
4. MSB_FIRST=0, word 0x01 -> data_s=1 on the first bit, then 0 for 7 bits.
5. Assert reset_n low at bit 3 of 0xF0 -> data_s=IDLE_BIT and frame_s=0 with no clock edge needed. After release, the next accepted word 0x3C is sent intact.
6. tx_data changed every cycle after the accept of 0x5A, and tx_valid toggled while tx_ready=0 -> the serialized output is exactly 0x5A and no extra words are accepted.
